// File: rtl/dmem_arbiter_if.sv
// ----------------------------------------------------------------------------
// dmem_arbiter_if
//   Bundles the three buses around the data-memory arbiter:
//     - CPU memory-stage request and load return (cpu_*)
//     - I/O requester request/grant and read return (io_*)
//     - single-port dmem address/data/write-enable and read data (mem_*)
//   Modports:
//     slave  : arbiter view (requests and mem_q in; grants, returns, mem_* out)
//     master : environment view (requesters plus the dmem itself)
//   ADDR_W/DATA_W must match the parameters of the dmem_arbiter it connects to.
// ----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
) ();

    // CPU memory stage
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    // I/O requester
    logic              io_req;
    logic              io_we;
    logic [ADDR_W-1:0] io_addr;
    logic [DATA_W-1:0] io_wdata;
    logic              io_gnt;
    logic              io_rvalid;
    logic [DATA_W-1:0] io_rdata;

    // Data memory
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rvalid, cpu_rdata,
        input  io_req, io_we, io_addr, io_wdata,
        output io_gnt, io_rvalid, io_rdata,
        output mem_addr, mem_wdata, mem_wren,
        input  mem_q
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rvalid, cpu_rdata,
        output io_req, io_we, io_addr, io_wdata,
        input  io_gnt, io_rvalid, io_rdata,
        input  mem_addr, mem_wdata, mem_wren,
        output mem_q
    );

endinterface

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single-port data memory between the CPU memory stage and an
//   I/O requester. One access is granted per cycle; the CPU normally wins and
//   is stalled when it loses. Read data returns one cycle after the grant,
//   straight from the clocked dmem read port, flagged to the owner of the read.
//   A streak counter bounds how many consecutive CPU grants may be taken while
//   the I/O side waits; reaching MAX_WAIT forces the next grant to I/O.
//
// Ports:
//   clock  : system clock, rising edge
//   reset  : asynchronous, active-low reset
//   bus    : dmem_arbiter_if.slave (cpu_*, io_*, mem_* signals)
//   stat_cpu_stalls / stat_io_forced : saturating statistics counters,
//            present only when DMEM_ARB_STATS_EN is defined
//
// Parameters:
//   ADDR_W   : dmem word-address width
//   DATA_W   : data width
//   MAX_WAIT : CPU grants allowed while io_req waits before I/O is forced,
//              legal range 1..15 (the streak counter is 4 bits)
//
// Optional build macro: DMEM_ARB_STATS_EN
// ----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    dmem_arbiter_if.slave     bus
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_cpu_stalls,
    output logic [15:0]       stat_io_forced
`endif
);

    // Arbitration state
    localparam logic [0:0] S_CPU_PRI  = 1'b0;
    localparam logic [0:0] S_IO_FORCE = 1'b1;

    // Owner of the read issued in the previous cycle
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_IO   = 2'd2;

    localparam logic [3:0] MAX_WAIT_4 = 4'(MAX_WAIT);

    logic [0:0] state_q, state_d;
    logic [3:0] streak_q, streak_d;
    logic [1:0] rd_owner_q, rd_owner_d;

    logic cpu_grant;
    logic io_grant;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wren;

    // ------------------------------------------------------------------------
    // Grant: combinational from live requests and registered state
    // ------------------------------------------------------------------------
    always_comb begin
        cpu_grant = 1'b0;
        io_grant  = 1'b0;
        if (state_q == S_IO_FORCE) begin
            // I/O is owed a slot; CPU only gets through if I/O has let go
            io_grant  = bus.io_req;
            cpu_grant = bus.cpu_req & ~bus.io_req;
        end else begin
            cpu_grant = bus.cpu_req;
            io_grant  = bus.io_req & ~bus.cpu_req;
        end
    end

    // ------------------------------------------------------------------------
    // Streak counter and state update
    // ------------------------------------------------------------------------
    always_comb begin
        streak_d = streak_q;
        if (io_grant || !bus.io_req) begin
            streak_d = 4'd0;
        end else if (cpu_grant) begin
            streak_d = streak_q + 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (streak_d == MAX_WAIT_4) begin
            state_d = S_IO_FORCE;
        end else if (state_q == S_IO_FORCE && (io_grant || !bus.io_req)) begin
            // Debt paid, or the requester withdrew (protocol violation): recover
            state_d = S_CPU_PRI;
        end
    end

    // ------------------------------------------------------------------------
    // Memory port mux
    // ------------------------------------------------------------------------
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wren  = 1'b0;
        if (cpu_grant) begin
            mem_addr  = bus.cpu_addr;
            mem_wdata = bus.cpu_wdata;
            mem_wren  = bus.cpu_we;
        end else if (io_grant) begin
            mem_addr  = bus.io_addr;
            mem_wdata = bus.io_wdata;
            mem_wren  = bus.io_we;
        end
    end

    // ------------------------------------------------------------------------
    // Read-return owner tracking
    // ------------------------------------------------------------------------
    always_comb begin
        rd_owner_d = OWN_NONE;
        if (cpu_grant && !bus.cpu_we) begin
            rd_owner_d = OWN_CPU;
        end else if (io_grant && !bus.io_we) begin
            rd_owner_d = OWN_IO;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_CPU_PRI;
            streak_q   <= 4'd0;
            rd_owner_q <= OWN_NONE;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.cpu_stall  = bus.cpu_req & ~cpu_grant;
    assign bus.io_gnt     = io_grant;

    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.mem_wren   = mem_wren;

    // dmem already registers the read, so data passes through untouched
    assign bus.cpu_rvalid = (rd_owner_q == OWN_CPU);
    assign bus.io_rvalid  = (rd_owner_q == OWN_IO);
    assign bus.cpu_rdata  = bus.mem_q;
    assign bus.io_rdata   = bus.mem_q;

`ifdef DMEM_ARB_STATS_EN
    // ------------------------------------------------------------------------
    // Statistics (saturating)
    // ------------------------------------------------------------------------
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] force_cnt_q, force_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.cpu_stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_comb begin
        force_cnt_d = force_cnt_q;
        if (state_q == S_CPU_PRI && state_d == S_IO_FORCE && force_cnt_q != '1) begin
            force_cnt_d = force_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            force_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            force_cnt_q <= force_cnt_d;
        end
    end

    assign stat_cpu_stalls = stall_cnt_q;
    assign stat_io_forced  = force_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed scenarios followed by randomized traffic. A behavioural model
//   tracks "CPU wins while I/O waits" as a plain integer, a reference word
//   array for memory contents, and the expected read return of the previous
//   cycle. A small clocked-read memory emulates dmem on the mem_* port.
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int unsigned ADDR_W   = 12;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MAX_WAIT = 4;

    logic clock;
    logic reset;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_cpu_stalls;
    logic [15:0] stat_io_forced;
`endif

    dmem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .bus             (bus)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_cpu_stalls (stat_cpu_stalls),
        .stat_io_forced  (stat_io_forced)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Power-on contents of dmem; word 0x010 is pinned for the first scenario
    function automatic logic [31:0] seed_word(input logic [ADDR_W-1:0] a);
        if (a == 12'h010) return 32'hDEADBEEF;
        return ({20'h0, a} * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // Emulated dmem: clocked read, write on mem_wren
    logic [31:0] emu_mem [4096];
    bit          emu_wr  [4096];
    always @(posedge clock) begin
        if (bus.mem_wren) begin
            emu_mem[bus.mem_addr] <= bus.mem_wdata;
            emu_wr[bus.mem_addr]  <= 1'b1;
        end
        bus.mem_q <= emu_wr[bus.mem_addr] ? emu_mem[bus.mem_addr] : seed_word(bus.mem_addr);
    end

    // Reference model state
    logic [31:0] ref_mem [4096];
    int          waits;       // consecutive CPU wins while I/O has been waiting
    bit          pend_cpu;
    bit          pend_io;
    logic [31:0] pend_data;
    bit          last_ig;

    // Per-cycle expectations carried from eval into commit
    bit              e_cg;
    bit              e_ig;
    bit              e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    bit              e_ioreq;

    int n_tests;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        waits    = 0;
        pend_cpu = 1'b0;
        pend_io  = 1'b0;
        last_ig  = 1'b0;
    endtask

    task automatic drive_cpu(input bit r, input bit w, input logic [11:0] a, input logic [31:0] d);
        bus.cpu_req   = r;
        bus.cpu_we    = w;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
    endtask

    task automatic drive_io(input bit r, input bit w, input logic [11:0] a, input logic [31:0] d);
        bus.io_req   = r;
        bus.io_we    = w;
        bus.io_addr  = a;
        bus.io_wdata = d;
    endtask

    // Sample at the falling edge and compare against the model
    task automatic eval();
        bit prio;
        @(negedge clock);
        prio    = (waits == int'(MAX_WAIT));
        e_cg    = bus.cpu_req && !(bus.io_req && prio);
        e_ig    = bus.io_req && !e_cg;
        e_ioreq = bus.io_req;
        e_we    = 1'b0;
        e_addr  = '0;
        e_data  = '0;
        if (e_cg) begin
            e_we = bus.cpu_we; e_addr = bus.cpu_addr; e_data = bus.cpu_wdata;
        end else if (e_ig) begin
            e_we = bus.io_we;  e_addr = bus.io_addr;  e_data = bus.io_wdata;
        end
        check("cpu_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req && !e_cg));
        check("io_gnt", 32'(bus.io_gnt), 32'(e_ig));
        check("mem_wren", 32'(bus.mem_wren), 32'((e_cg || e_ig) && e_we));
        check("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
        check("mem_wdata", bus.mem_wdata, e_data);
        check("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(pend_cpu));
        check("io_rvalid", 32'(bus.io_rvalid), 32'(pend_io));
        if (pend_cpu) check("cpu_rdata", bus.cpu_rdata, pend_data);
        if (pend_io) check("io_rdata", bus.io_rdata, pend_data);
    endtask

    // Advance the model across the rising edge; return at edge + 1
    task automatic commit();
        @(posedge clock);
        if ((e_cg || e_ig) && e_we) ref_mem[e_addr] = e_data;
        pend_cpu  = e_cg && !e_we;
        pend_io   = e_ig && !e_we;
        pend_data = ref_mem[e_addr];
        waits     = (e_cg && e_ioreq) ? waits + 1 : 0;
        last_ig   = e_ig;
        #1;
    endtask

    task automatic step();
        eval();
        commit();
    endtask

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] s0_stalls;
    logic [15:0] s0_forced;
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = seed_word(12'(i));
        model_reset();

        // Reset and release
        reset = 1'b0;
        drive_cpu(1'b0, 1'b0, 12'h0, 32'h0);
        drive_io(1'b0, 1'b0, 12'h0, 32'h0);
        repeat (2) @(posedge clock);
        #1;
        check("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        check("rst_io_rvalid", 32'(bus.io_rvalid), 32'd0);
        check("rst_mem_wren", 32'(bus.mem_wren), 32'd0);
        reset = 1'b1;

        // 1: CPU read of 0x010
        drive_cpu(1'b1, 1'b0, 12'h010, 32'h0);
        eval();
        check("t1_stall", 32'(bus.cpu_stall), 32'd0);
        check("t1_addr", 32'(bus.mem_addr), 32'h010);
        commit();
        drive_cpu(1'b0, 1'b0, 12'h0, 32'h0);
        eval();
        check("t1_rvalid", 32'(bus.cpu_rvalid), 32'd1);
        check("t1_rdata", bus.cpu_rdata, 32'hDEADBEEF);
        check("t1_io_rvalid", 32'(bus.io_rvalid), 32'd0);
        commit();

        // 2: I/O write 0x3FF
        drive_io(1'b1, 1'b1, 12'h3FF, 32'h12345678);
        eval();
        check("t2_gnt", 32'(bus.io_gnt), 32'd1);
        check("t2_wren", 32'(bus.mem_wren), 32'd1);
        check("t2_wdata", bus.mem_wdata, 32'h12345678);
        commit();
        drive_io(1'b0, 1'b0, 12'h0, 32'h0);
        step();

        // 3: both requesting continuously; I/O gets every 5th slot
`ifdef DMEM_ARB_STATS_EN
        s0_stalls = stat_cpu_stalls;
        s0_forced = stat_io_forced;
`endif
        drive_io(1'b1, 1'b0, 12'h3FF, 32'h0);
        for (int k = 1; k <= 20; k++) begin
            drive_cpu(1'b1, 1'b0, 12'(k), 32'h0);
            eval();
            check("t3_io_gnt", 32'(bus.io_gnt), 32'((k % 5) == 0));
            commit();
        end
`ifdef DMEM_ARB_STATS_EN
        check("t6_stalls", stat_cpu_stalls - s0_stalls, 32'd4);
        check("t6_forced", 32'(stat_io_forced - s0_forced), 32'd4);
`endif
        drive_cpu(1'b0, 1'b0, 12'h0, 32'h0);
        drive_io(1'b0, 1'b0, 12'h0, 32'h0);
        step();

        // 4: alternating owners of back-to-back reads
        drive_cpu(1'b1, 1'b0, 12'h004, 32'h0);
        step();
        drive_cpu(1'b0, 1'b0, 12'h0, 32'h0);
        drive_io(1'b1, 1'b0, 12'h008, 32'h0);
        eval();
        check("t4_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
        check("t4_cpu_rdata", bus.cpu_rdata, seed_word(12'h004));
        commit();
        drive_io(1'b0, 1'b0, 12'h0, 32'h0);
        eval();
        check("t4_io_rvalid", 32'(bus.io_rvalid), 32'd1);
        check("t4_io_rdata", bus.io_rdata, seed_word(12'h008));
        commit();

        // 5: build a streak, then reset while a CPU read return is pending
        drive_io(1'b1, 1'b0, 12'h020, 32'h0);
        for (int k = 0; k < 3; k++) begin
            drive_cpu(1'b1, 1'b0, 12'(k + 32), 32'h0);
            step();
        end
        drive_cpu(1'b0, 1'b0, 12'h0, 32'h0);
        drive_io(1'b0, 1'b0, 12'h0, 32'h0);
        reset = 1'b0;
        #1;
        check("t5_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        check("t5_io_rvalid", 32'(bus.io_rvalid), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
        drive_io(1'b1, 1'b0, 12'h020, 32'h0);
        for (int k = 0; k < 4; k++) begin
            drive_cpu(1'b1, 1'b0, 12'(k + 40), 32'h0);
            eval();
            check("t5_cpu_first", 32'(bus.cpu_stall), 32'd0);
            commit();
        end

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            drive_cpu($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                      12'($urandom_range(0, 15)), $urandom);
            if (bus.io_req && !last_ig) begin
                // Waiting requests hold; rarely withdraw to exercise recovery
                if ($urandom_range(0, 63) == 0) bus.io_req = 1'b0;
            end else begin
                drive_io($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                         12'($urandom_range(0, 15)), $urandom);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
